jtopl_timers_pair: RTL and testbench
====================================

# jtopl_timers_pair

Timer A / Timer B block for the OPL core. It consumes the operator-rate clock enable `cenop` from the divider and derives a sample tick from it. It runs the two programmable 8-bit up-counters of the OPL register map (A: 80 µs resolution, B: 320 µs resolution) and produces the status flags and interrupt line read back by the CPU interface. It sits beside the register file: control values arrive as levels/pulses from the register decoder; flags go to the status read mux and the CSM logic.

## Interface
Parameters:
- `SLOTS`, 18, operator slots per sample; `cenop` pulses per sample tick
- `PRE_A`, 4, sample ticks per Timer A count
- `PRE_B`, 16, sample ticks per Timer B count

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `cenop`  in  1  operator-rate clock enable, one `clk` wide
- `value_a`  in  8  Timer A reload value (reg 0x02)
- `value_b`  in  8  Timer B reload value (reg 0x03)
- `load_a`, `load_b`  in  1  start bits (reg 0x04 b0/b1), level
- `mask_a`, `mask_b`  in  1  flag masks (reg 0x04 b6/b5), level
- `irq_rst`  in  1  one-cycle pulse, reg 0x04 b7 written as 1
- `flag_a`, `flag_b`  out  1  status bits 6/5
- `irq_n`  out  1  active-low interrupt, `~(flag_a | flag_b)`; status bit 7 is its inverse
- `ovf_a`  out  1  one-cycle pulse on every Timer A overflow (CSM key-on)

## Operation
- Slot counter, 5 bits, 0..SLOTS-1: advances on `cenop`, wraps to 0. `smp_tick` = `cenop && slot==SLOTS-1`.
- Prescaler A is 2 bits, prescaler B is 4 bits. Each advances on `smp_tick` and wraps. `tick_a`/`tick_b` assert on `smp_tick` when the prescaler is at max. Prescalers run freely, independent of the load bits.
- Per timer, 8-bit counter `cnt`:
  - Rising edge of `load_x` (registered compare, sampled every `clk`): `cnt <= value_x`. This takes priority over a tick in the same cycle.
  - `load_x`=1 and `tick_x` with `cnt`≠0xFF: `cnt <= cnt+1`.
  - `load_x`=1 and `tick_x` with `cnt`==0xFF: overflow. `cnt <= value_x`, current value rather than the value latched at start.
  - `load_x`=0: `cnt` holds its value. A later rising edge reloads it.
- Flag update on overflow: `flag_x <= 1` unless `mask_x`.
- `mask_x`=1 forces `flag_x` to 0 on every cycle it is high.
- `irq_rst` clears both flags.
- `irq_rst` coincident with an overflow: the set wins, so no event is lost.
- `ovf_a` pulses on a Timer A overflow regardless of `mask_a`. Timer B has no pulse output.
- `value_x` = 0xFF: overflow on every `tick_x`.

## Timing
- Reset values: slot, prescalers and counters 0; `flag_a`=`flag_b`=0; `irq_n`=1; `ovf_a`=0; load-edge registers 0.
- All outputs are registered.
- Overflow latency: the `clk` after the `cenop` that produced the terminal tick shows `cnt`=reload, `flag_x`=1 and `ovf_a`=1. `ovf_a` is exactly 1 `clk` wide. `irq_n` falls on the same cycle as the flag.
- Overflow period: `(256-value_x)·PRE_x·SLOTS` `cenop` pulses, measured from the first tick after the load edge. The first period is shortened by the current prescaler/slot phase, because the prescalers free-run.
- `irq_rst` takes effect on the next `clk`.
- `rst` asserted mid-count returns everything to reset values on the next edge. No pending overflow survives.
- Without `cenop`, all state freezes except the flag mask/clear logic and load-edge detection.

## Structure
- Shared package: `SLOTS`, `PRE_A`, `PRE_B` defaults and the status bit positions (7/6/5).
- One sub-module, `jtopl_timer_cnt`, is natural. It holds one 8-bit counter, load-edge detect, overflow, and flag set/mask/clear. It is instantiated twice, with the prescaler tick as its enable.
- The top level holds the slot counter and the two prescalers.

## Test plan
- Reset with `cenop` every 4 `clk`: all outputs at reset values; `irq_n`=1; slot counter returns to 0 after 18 `cenop`.
- `value_a`=0xFF, `load_a`=1 from reset: `flag_a` rises within 4·18 `cenop` (≤288 `clk`), then `ovf_a` pulses every 72 `cenop`; `irq_n`=0.
- `value_b`=0xFE, `load_b`=1: first overflow then every 2·16·18=576 `cenop`; `flag_b`=1 and `flag_a` stays 0.
- `mask_a`=1 with Timer A overflowing: `flag_a` stays 0 and `ovf_a` still pulses. Raising `mask_a` after a flag is set clears `flag_a` next `clk`.
- `irq_rst` on the same `clk` as a Timer A overflow: `flag_a`=1 afterwards. `irq_rst` alone: both flags 0 and `irq_n`=1 next `clk`.
- `load_a` dropped mid-count at `cnt`=0x80, then raised with `value_a`=0x10: `cnt` holds 0x80 while low, then becomes 0x10 on the edge; the next overflow comes after 240 A-ticks.

Source files
------------

// File: rtl/jtopl_timers_pair_pkg.sv
// Shared constants for the OPL Timer A / Timer B block: default timing
// parameters and the positions of the timer bits in the status byte.
package jtopl_timers_pair_pkg;

    localparam int SLOTS_DEF = 18;
    localparam int PRE_A_DEF = 4;
    localparam int PRE_B_DEF = 16;

    localparam int ST_IRQ_BIT    = 7;
    localparam int ST_FLAG_A_BIT = 6;
    localparam int ST_FLAG_B_BIT = 5;

endpackage

// File: rtl/jtopl_timers_pair_cnt.sv
// One OPL timer: 8-bit up-counter with load-edge reload, overflow reload
// from the live value register, and a maskable, clearable status flag.
module jtopl_timer_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       mask,
    input  logic       irq_rst,
    output logic       flag,
    output logic       ovf
);

    logic [7:0] cnt;
    logic       load_l;
    logic       load_edge;
    logic       overflow;

    assign load_edge = load & ~load_l;
    // A start edge reloads the counter and suppresses any tick in that cycle.
    assign overflow  = load & ~load_edge & tick & (cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            load_l <= 1'b0;
            cnt    <= 8'd0;
            flag   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            load_l <= load;
            ovf    <= overflow;
            if (load_edge) begin
                cnt <= value;
            end else if (load && tick) begin
                cnt <= overflow ? value : cnt + 8'd1;
            end
            // Overflow beats irq_rst so a coincident event is never lost.
            if (mask) begin
                flag <= 1'b0;
            end else if (overflow) begin
                flag <= 1'b1;
            end else if (irq_rst) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtopl_timers_pair.sv
// Timer A / Timer B pair: derives the sample tick and the two prescaled
// timer ticks from cenop, and combines the timer flags into irq_n.
module jtopl_timers_pair
    import jtopl_timers_pair_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEF,
    parameter int PRE_A = PRE_A_DEF,
    parameter int PRE_B = PRE_B_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic [7:0] value_a,
    input  logic [7:0] value_b,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       mask_a,
    input  logic       mask_b,
    input  logic       irq_rst,
    output logic       flag_a,
    output logic       flag_b,
    output logic       irq_n,
    output logic       ovf_a
);

    localparam logic [4:0] SLOT_MAX  = 5'(SLOTS - 1);
    localparam logic [1:0] PRE_A_MAX = 2'(PRE_A - 1);
    localparam logic [3:0] PRE_B_MAX = 4'(PRE_B - 1);

    logic [4:0] slot;
    logic [1:0] pre_a;
    logic [3:0] pre_b;
    logic       smp_tick;
    logic       tick_a;
    logic       tick_b;
    logic       ovf_b_unused;

    assign smp_tick = cenop & (slot == SLOT_MAX);
    assign tick_a   = smp_tick & (pre_a == PRE_A_MAX);
    assign tick_b   = smp_tick & (pre_b == PRE_B_MAX);

    // Prescalers free-run regardless of the load bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot  <= 5'd0;
            pre_a <= 2'd0;
            pre_b <= 4'd0;
        end else if (cenop) begin
            slot <= (slot == SLOT_MAX) ? 5'd0 : slot + 5'd1;
            if (smp_tick) begin
                pre_a <= tick_a ? 2'd0 : pre_a + 2'd1;
                pre_b <= tick_b ? 4'd0 : pre_b + 4'd1;
            end
        end
    end

    jtopl_timer_cnt u_timer_a (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_a),
        .value   (value_a),
        .load    (load_a),
        .mask    (mask_a),
        .irq_rst (irq_rst),
        .flag    (flag_a),
        .ovf     (ovf_a)
    );

    jtopl_timer_cnt u_timer_b (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_b),
        .value   (value_b),
        .load    (load_b),
        .mask    (mask_b),
        .irq_rst (irq_rst),
        .flag    (flag_b),
        .ovf     (ovf_b_unused)
    );

    assign irq_n = ~(flag_a | flag_b);

endmodule

// File: tb/tb_jtopl_timers_pair.sv
// Self-checking bench for jtopl_timers_pair: directed scenarios plus a random
// phase, all compared every cycle against a count-based reference model.
module tb_jtopl_timers_pair;

    localparam int SLOTS = 18;
    localparam int PRE_A = 4;
    localparam int PRE_B = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cenop;
    logic [7:0] value_a;
    logic [7:0] value_b;
    logic       load_a;
    logic       load_b;
    logic       mask_a;
    logic       mask_b;
    logic       irq_rst;
    logic       flag_a;
    logic       flag_b;
    logic       irq_n;
    logic       ovf_a;

    always #5 clk = ~clk;

    jtopl_timers_pair #(.SLOTS(SLOTS), .PRE_A(PRE_A), .PRE_B(PRE_B)) dut (
        .clk     (clk),
        .rst     (rst),
        .cenop   (cenop),
        .value_a (value_a),
        .value_b (value_b),
        .load_a  (load_a),
        .load_b  (load_b),
        .mask_a  (mask_a),
        .mask_b  (mask_b),
        .irq_rst (irq_rst),
        .flag_a  (flag_a),
        .flag_b  (flag_b),
        .irq_n   (irq_n),
        .ovf_a   (ovf_a)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cen_period = 4;

    // Reference model: timing derived from the total number of cenop pulses.
    int m_cenops = 0;
    int m_cnt[2];
    bit m_prev[2];
    bit m_flag[2];
    bit m_ovf[2];
    int m_ticks[2];

    task automatic modelStep();
        bit ld[2];
        bit msk[2];
        bit tk[2];
        int val[2];
        bit smp;
        bit is_edge;
        int sample;
        if (rst) begin
            m_cenops = 0;
            for (int t = 0; t < 2; t++) begin
                m_cnt[t] = 0; m_prev[t] = 0; m_flag[t] = 0; m_ovf[t] = 0; m_ticks[t] = 0;
            end
            return;
        end
        ld[0] = load_a;  ld[1] = load_b;
        msk[0] = mask_a; msk[1] = mask_b;
        val[0] = int'(value_a); val[1] = int'(value_b);
        smp    = cenop && (m_cenops % SLOTS == SLOTS - 1);
        sample = m_cenops / SLOTS;
        tk[0]  = smp && (sample % PRE_A == PRE_A - 1);
        tk[1]  = smp && (sample % PRE_B == PRE_B - 1);
        if (cenop) m_cenops++;
        for (int t = 0; t < 2; t++) begin
            is_edge  = ld[t] && !m_prev[t];
            m_ovf[t] = 0;
            if (is_edge) begin
                m_cnt[t]   = val[t];
                m_ticks[t] = 0;
            end else if (ld[t] && tk[t]) begin
                m_ticks[t]++;
                if (m_cnt[t] == 255) begin
                    m_cnt[t] = val[t];
                    m_ovf[t] = 1;
                end else begin
                    m_cnt[t]++;
                end
            end
            if (msk[t])        m_flag[t] = 0;
            else if (m_ovf[t]) m_flag[t] = 1;
            else if (irq_rst)  m_flag[t] = 0;
            m_prev[t] = ld[t];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus();
        if (cen_period == 0) cenop = 1'($urandom_range(0, 1));
        else                 cenop = (cyc % cen_period == 0);
        @(posedge clk);
        modelStep();
        cyc++;
        #1;
        checkOutput("flag_a", 8'(flag_a), 8'(m_flag[0]));
        checkOutput("flag_b", 8'(flag_b), 8'(m_flag[1]));
        checkOutput("irq_n",  8'(irq_n),  8'(!(m_flag[0] || m_flag[1])));
        checkOutput("ovf_a",  8'(ovf_a),  8'(m_ovf[0]));
    endtask

    // which: 0 = flag_a, 1 = flag_b, 2 = ovf_a
    task automatic waitFor(input int which, input int bound, input string tag);
        bit found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            applyStimulus();
            case (which)
                0:       found = flag_a;
                1:       found = flag_b;
                default: found = ovf_a;
            endcase
        end
        checkOutput(tag, 8'(found), 8'd1);
    endtask

    task automatic pulseIrqRst();
        irq_rst = 1'b1;
        applyStimulus();
        irq_rst = 1'b0;
    endtask

    initial begin
        int t0;
        rst = 1'b1; cenop = 1'b0; value_a = 8'h00; value_b = 8'h00;
        load_a = 1'b0; load_b = 1'b0; mask_a = 1'b0; mask_b = 1'b0; irq_rst = 1'b0;

        $display("[TB] reset");
        repeat (3) applyStimulus();
        checkOutput("rst_irq_n", 8'(irq_n), 8'd1);
        checkOutput("rst_ovf_a", 8'(ovf_a), 8'd0);
        rst = 1'b0;
        repeat (72) applyStimulus();
        checkOutput("slot_wrap_cenops", 8'(m_cenops), 8'd18);
        checkOutput("slot_wrap", 8'(dut.slot), 8'd0);

        $display("[TB] timer A at 0xFF");
        value_a = 8'hFF; load_a = 1'b1;
        waitFor(0, 290, "flag_a_first");
        checkOutput("irq_n_low", 8'(irq_n), 8'd0);
        t0 = cyc;
        applyStimulus();
        waitFor(2, 400, "ovf_a_second");
        checkOutput("ovf_a_period", 8'((cyc - t0) / 4), 8'd72);
        checkOutput("ovf_a_period_exact", 8'((cyc - t0) % 4), 8'd0);

        $display("[TB] timer B at 0xFE");
        load_a = 1'b0;
        pulseIrqRst();
        checkOutput("clr_irq_n", 8'(irq_n), 8'd1);
        value_b = 8'hFE; load_b = 1'b1;
        waitFor(1, 4700, "flag_b_first");
        checkOutput("flag_a_quiet", 8'(flag_a), 8'd0);
        t0 = cyc;
        pulseIrqRst();
        checkOutput("flag_b_cleared", 8'(flag_b), 8'd0);
        waitFor(1, 2400, "flag_b_second");
        checkOutput("flag_b_period", 8'((cyc - t0) / 16), 8'd144);
        checkOutput("flag_b_period_exact", 8'((cyc - t0) % 16), 8'd0);

        $display("[TB] mask A");
        load_b = 1'b0;
        pulseIrqRst();
        mask_a = 1'b1; value_a = 8'hFF; load_a = 1'b1;
        waitFor(2, 300, "ovf_a_masked");
        checkOutput("flag_a_masked", 8'(flag_a), 8'd0);
        mask_a = 1'b0;
        applyStimulus();
        waitFor(2, 300, "ovf_a_unmasked");
        checkOutput("flag_a_unmasked", 8'(flag_a), 8'd1);
        mask_a = 1'b1;
        applyStimulus();
        checkOutput("flag_a_mask_clr", 8'(flag_a), 8'd0);
        checkOutput("irq_n_mask_clr", 8'(irq_n), 8'd1);
        mask_a = 1'b0;

        $display("[TB] irq_rst against overflow");
        applyStimulus();
        waitFor(2, 300, "ovf_a_sync");
        repeat (287) applyStimulus();
        pulseIrqRst();
        checkOutput("coinc_ovf_a", 8'(ovf_a), 8'd1);
        checkOutput("coinc_flag_a", 8'(flag_a), 8'd1);
        pulseIrqRst();
        checkOutput("irq_rst_flag_a", 8'(flag_a), 8'd0);
        checkOutput("irq_rst_flag_b", 8'(flag_b), 8'd0);
        checkOutput("irq_rst_irq_n", 8'(irq_n), 8'd1);

        $display("[TB] load hold and reload");
        cen_period = 1;
        load_a = 1'b0; applyStimulus();
        value_a = 8'h70; load_a = 1'b1;
        begin
            bit hit = 0;
            for (int i = 0; i < 1500 && !hit; i++) begin
                applyStimulus();
                hit = (m_cnt[0] == 8'h80);
            end
            checkOutput("reach_0x80", 8'(hit), 8'd1);
        end
        load_a = 1'b0;
        applyStimulus();
        checkOutput("hold_0x80_a", dut.u_timer_a.cnt, 8'h80);
        repeat (200) applyStimulus();
        checkOutput("hold_0x80_b", dut.u_timer_a.cnt, 8'h80);
        value_a = 8'h10; load_a = 1'b1;
        applyStimulus();
        checkOutput("reload_0x10", dut.u_timer_a.cnt, 8'h10);
        waitFor(2, 17400, "ovf_after_reload");
        checkOutput("ticks_to_ovf", 8'(m_ticks[0]), 8'd240);

        $display("[TB] random phase");
        cen_period = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) load_a = ~load_a;
            if ($urandom_range(0, 199) == 0) load_b = ~load_b;
            if ($urandom_range(0, 149) == 0) mask_a = ~mask_a;
            if ($urandom_range(0, 149) == 0) mask_b = ~mask_b;
            if ($urandom_range(0, 31) == 0)  value_a = 8'($urandom_range(8'hF8, 8'hFF));
            if ($urandom_range(0, 31) == 0)  value_b = 8'($urandom_range(8'hFC, 8'hFF));
            irq_rst = ($urandom_range(0, 39) == 0);
            rst = (i == 1500);
            applyStimulus();
            if (i == 1500) begin
                checkOutput("midrst_cnt_a", dut.u_timer_a.cnt, 8'h00);
                checkOutput("midrst_slot", 8'(dut.slot), 8'h00);
            end
        end
        rst = 1'b0; irq_rst = 1'b0;
        applyStimulus();
        checkOutput("slot_final", 8'(dut.slot), 8'(m_cenops % SLOTS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
